// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: decode-stage forwarding scoreboard.
// Tracks in-flight destination tags and captured results for every downstream
// stage, forwards youngest-first to NSRC decode operands, and detects load-use
// hazards, inserting one bubble per stalled cycle and counting stall cycles.
module fwd_scoreboard #(
    parameter int unsigned NSRC   = 2,
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid_i,
    input  logic [REG_W-1:0]         issue_dstE_i,
    input  logic [REG_W-1:0]         issue_dstM_i,
    input  logic                     flush_i,
    input  logic [NSRC*REG_W-1:0]    d_src_i,
    input  logic [NSRC*DATA_W-1:0]   d_rval_i,
    input  logic                     sel_valp_i,
    input  logic [DATA_W-1:0]        D_valP_i,
    input  logic [DATA_W-1:0]        e_valE_i,
    input  logic [DATA_W-1:0]        m_valM_i,
    output logic [NSRC*DATA_W-1:0]   d_val_o,
    output logic                     stall_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam logic [REG_W-1:0] RNONE = '1;

    // Per-stage tags; valE exists from M onward, valM from W onward
    // (the M-stage load result is the live m_valM_i).
    logic [REG_W-1:0]  r_dstE [NSTAGE];
    logic [REG_W-1:0]  r_dstM [NSTAGE];
    logic [DATA_W-1:0] r_valE [1:NSTAGE-1];
    logic [DATA_W-1:0] r_valM [2:NSTAGE-1];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [NSRC*DATA_W-1:0] w_d_val;
    logic                   w_stall;
    logic                   w_issue;

    // Youngest-first forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_d_val = d_rval_i;
        for (int k = 0; k < NSRC; k++) begin
            logic [REG_W-1:0]  src;
            logic [DATA_W-1:0] val;
            src = d_src_i[k*REG_W +: REG_W];
            val = d_rval_i[k*DATA_W +: DATA_W];
            for (int s = NSTAGE - 1; s >= 2; s--) begin
                if (r_dstE[s] == src) val = r_valE[s];
                if (r_dstM[s] == src) val = r_valM[s];
            end
            if (r_dstE[1] == src) val = r_valE[1];
            if (r_dstM[1] == src) val = m_valM_i;
            if (r_dstE[0] == src) val = e_valE_i;
            if (src == RNONE)     val = d_rval_i[k*DATA_W +: DATA_W];
            if (k == 0 && sel_valp_i) val = D_valP_i;
            w_d_val[k*DATA_W +: DATA_W] = val;
        end
    end

    // Load-use hazard: an operand needs the result of the load currently in E.
    always_comb begin
        w_stall = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (!(k == 0 && sel_valp_i) &&
                d_src_i[k*REG_W +: REG_W] != RNONE &&
                d_src_i[k*REG_W +: REG_W] == r_dstM[0])
                w_stall = 1'b1;
        end
    end

    assign w_issue = issue_valid_i && !flush_i && !w_stall;

    // Pipeline shift: stage 0 takes the issuing instruction or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                r_dstE[s] <= RNONE;
                r_dstM[s] <= RNONE;
            end
            for (int s = 1; s < NSTAGE; s++) r_valE[s] <= '0;
            for (int s = 2; s < NSTAGE; s++) r_valM[s] <= '0;
        end else begin
            r_dstE[0] <= w_issue ? issue_dstE_i : RNONE;
            r_dstM[0] <= w_issue ? issue_dstM_i : RNONE;
            r_dstE[1] <= r_dstE[0];
            r_dstM[1] <= r_dstM[0];
            r_valE[1] <= e_valE_i;
            r_dstE[2] <= r_dstE[1];
            r_dstM[2] <= r_dstM[1];
            r_valE[2] <= r_valE[1];
            r_valM[2] <= m_valM_i;
            for (int s = 3; s < NSTAGE; s++) begin
                r_dstE[s] <= r_dstE[s-1];
                r_dstM[s] <= r_dstM[s-1];
                r_valE[s] <= r_valE[s-1];
                r_valM[s] <= r_valM[s-1];
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign d_val_o     = w_d_val;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (NSRC=2, NSTAGE=3, CNT_W=2).
module tb_fwd_scoreboard;

    localparam int unsigned NSRC   = 2;
    localparam int unsigned NSTAGE = 3;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;
    localparam logic [3:0]  RN     = 4'hF;

    logic                   clk;
    logic                   rst;
    logic                   issue_valid_i;
    logic [REG_W-1:0]       issue_dstE_i;
    logic [REG_W-1:0]       issue_dstM_i;
    logic                   flush_i;
    logic [NSRC*REG_W-1:0]  d_src_i;
    logic [NSRC*DATA_W-1:0] d_rval_i;
    logic                   sel_valp_i;
    logic [DATA_W-1:0]      D_valP_i;
    logic [DATA_W-1:0]      e_valE_i;
    logic [DATA_W-1:0]      m_valM_i;
    logic [NSRC*DATA_W-1:0] d_val_o;
    logic                   stall_o;
    logic [CNT_W-1:0]       stall_cnt_o;

    int checks = 0;
    int errors = 0;

    fwd_scoreboard #(
        .NSRC(NSRC), .NSTAGE(NSTAGE), .REG_W(REG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_dstE_i(issue_dstE_i),
        .issue_dstM_i(issue_dstM_i), .flush_i(flush_i),
        .d_src_i(d_src_i), .d_rval_i(d_rval_i),
        .sel_valp_i(sel_valp_i), .D_valP_i(D_valP_i),
        .e_valE_i(e_valE_i), .m_valM_i(m_valM_i),
        .d_val_o(d_val_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] op(input int k);
        return d_val_o[k*DATA_W +: DATA_W];
    endfunction

    task automatic issue(input logic v, input logic [3:0] de, input logic [3:0] dm);
        issue_valid_i = v;
        issue_dstE_i  = de;
        issue_dstM_i  = dm;
    endtask

    initial begin
        rst = 1'b1;
        issue(1'b0, RN, RN);
        flush_i    = 1'b0;
        d_src_i    = {4'd2, 4'd1};
        d_rval_i   = {32'h22, 32'h11};
        sel_valp_i = 1'b0;
        D_valP_i   = 32'h0;
        e_valE_i   = 32'h0;
        m_valM_i   = 32'h0;
        #2;
        check("rst_op0", op(0), 32'h11);
        check("rst_op1", op(1), 32'h22);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_cnt", 32'(stall_cnt_o), 32'h0);

        // E-forwarding and youngest-wins
        rst = 1'b0;
        d_src_i = {RN, RN};
        issue(1'b1, 4'd3, RN);
        tick();
        d_src_i  = {RN, 4'd3};
        e_valE_i = 32'hAA;
        #1;
        check("e_fwd", op(0), 32'hAA);
        tick();
        issue(1'b0, RN, RN);
        e_valE_i = 32'hBB;
        #1;
        check("young_wins", op(0), 32'hBB);
        tick();
        e_valE_i = 32'hCC;
        #1;
        check("m_valE_fwd", op(0), 32'hBB);
        tick();
        check("w_valE_fwd", op(0), 32'hBB);
        tick();
        check("drained", op(0), 32'h11);

        // Load-use hazard with issue ignored while stalled
        d_src_i = {RN, RN};
        issue(1'b1, RN, 4'd5);
        tick();
        issue(1'b1, 4'd7, RN);
        d_src_i = {4'd5, RN};
        #1;
        check("lu_stall", 32'(stall_o), 32'h1);
        tick();
        issue(1'b0, RN, RN);
        d_src_i  = {4'd5, 4'd7};
        m_valM_i = 32'h55;
        #1;
        check("lu_fwd", op(1), 32'h55);
        check("lu_nostall", 32'(stall_o), 32'h0);
        check("lu_cnt", 32'(stall_cnt_o), 32'h1);
        check("stalled_issue_dropped", op(0), 32'h11);
        d_src_i = {RN, RN};
        tick(); tick(); tick();

        // Same-stage order: valM beats valE for one instruction
        issue(1'b1, 4'd4, 4'd4);
        tick();
        issue(1'b0, RN, RN);
        e_valE_i = 32'h40;
        tick();
        e_valE_i = 32'h0;
        m_valM_i = 32'h44;
        d_src_i  = {RN, 4'd4};
        #1;
        check("m_valM_over_valE", op(0), 32'h44);
        tick();
        m_valM_i = 32'h0;
        #1;
        check("w_valM_over_valE", op(0), 32'h44);
        d_src_i = {RN, RN};
        tick(); tick();

        // sel_valp overrides forwarding and masks operand 0 hazard
        issue(1'b1, 4'd9, 4'd9);
        tick();
        issue(1'b0, RN, RN);
        sel_valp_i = 1'b1;
        D_valP_i   = 32'h100;
        e_valE_i   = 32'h99;
        d_src_i    = {RN, 4'd9};
        #1;
        check("valp_op0", op(0), 32'h100);
        check("valp_nostall", 32'(stall_o), 32'h0);
        d_src_i = {4'd9, 4'd9};
        #1;
        check("valp_op1_stall", 32'(stall_o), 32'h1);
        d_src_i    = {RN, RN};
        sel_valp_i = 1'b0;
        #1;
        tick(); tick(); tick();

        // Flushed issue never matches
        issue(1'b1, 4'd6, RN);
        flush_i = 1'b1;
        tick();
        issue(1'b0, RN, RN);
        flush_i  = 1'b0;
        e_valE_i = 32'h66;
        d_src_i  = {RN, 4'd6};
        #1;
        check("flush_e", op(0), 32'h11);
        tick();
        check("flush_m", op(0), 32'h11);
        d_src_i = {RN, RN};
        tick(); tick();

        // Reset mid-operation clears tags immediately
        issue(1'b1, 4'd2, RN);
        tick();
        issue(1'b0, RN, RN);
        e_valE_i = 32'h77;
        d_src_i  = {RN, 4'd2};
        #1;
        check("pre_rst_fwd", op(0), 32'h77);
        rst = 1'b1;
        #1;
        check("mid_rst_op0", op(0), 32'h11);
        check("mid_rst_cnt", 32'(stall_cnt_o), 32'h0);
        rst = 1'b0;
        d_src_i = {RN, RN};
        tick();

        // Counter saturation over five stalled cycles
        for (int i = 0; i < 5; i++) begin
            d_src_i = {RN, RN};
            issue(1'b1, RN, 4'd8);
            tick();
            issue(1'b0, RN, RN);
            d_src_i = {4'd8, RN};
            #1;
            check("sat_stall", 32'(stall_o), 32'h1);
            tick();
            check("sat_cnt", 32'(stall_cnt_o), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
